// File: rtl/rf_spi_pkg.sv
// rtl/rf_spi_pkg.sv - shared types, constants and command decode helpers for the RF SPI responder
package rf_spi_pkg;

  localparam int             DEF_ADDR_W       = 10;
  localparam logic [9:0]     DEF_INTSTAT_ADDR = 10'h031;

  localparam int SHORT_CMD_BITS = 8;
  localparam int LONG_CMD_BITS  = 16;
  localparam int DATA_BITS      = 8;

  typedef enum logic {
    SHORT,
    LONG
  } access_t;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LADDR,
    DATA_WR,
    DATA_RD,
    DONE
  } state_t;

  // Register address carried by the final address byte; hi is the long-form upper field.
  function automatic logic [DEF_ADDR_W-1:0] decode_addr(access_t acc, logic [6:0] hi,
                                                        logic [7:0] b);
    if (acc == SHORT) return {4'b0000, b[6:1]};
    return {hi, b[7:5]};
  endfunction

  // Write flag sits in bit 0 of a short command and bit 4 of the long second byte.
  function automatic logic decode_write(access_t acc, logic [7:0] b);
    return (acc == SHORT) ? b[0] : b[4];
  endfunction

endpackage

// File: rtl/rf_spi_responder_if.sv
// rtl/rf_spi_responder_if.sv - SPI pins, register-file port and interrupt lines of the responder
interface rf_spi_responder_if #(
  parameter int ADDR_W = 10
);
  logic              cs;
  logic              sck;
  logic              sdi;
  logic              sdo;
  logic              sdo_oe;
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_wr;
  logic [7:0]        reg_wdata;
  logic              reg_rd;
  logic [7:0]        reg_rdata;
  logic              irq_req;
  logic              intr_n;

  modport slave (
    input  cs, sck, sdi, reg_rdata, irq_req,
    output sdo, sdo_oe, reg_addr, reg_wr, reg_wdata, reg_rd, intr_n
  );

  modport master (
    output cs, sck, sdi, reg_rdata, irq_req,
    input  sdo, sdo_oe, reg_addr, reg_wr, reg_wdata, reg_rd, intr_n
  );
endinterface

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - SPI pin synchronizer and sck edge detector
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic sck,
  input  logic sdi,
  output logic cs_s,
  output logic sdi_s,
  output logic sck_rise,
  output logic sck_fall
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   sck_d;

  // Shift the raw pins through the synchronizer chains; cs idles deasserted (high).
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync  <= '1;
      sck_sync <= '0;
      sdi_sync <= '0;
      sck_d    <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      sck_d    <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_sync[SYNC_STAGES-1] & ~sck_d;
  assign sck_fall = ~sck_sync[SYNC_STAGES-1] & sck_d;

endmodule

// File: rtl/rf_spi_responder.sv
// rtl/rf_spi_responder.sv - SPI slave model of the RF transceiver host register interface
module rf_spi_responder
  import rf_spi_pkg::*;
#(
  parameter int                ADDR_W       = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] INTSTAT_ADDR = ADDR_W'(DEF_INTSTAT_ADDR),
  parameter int                SYNC_STAGES  = 2
) (
  input logic               clk,
  input logic               rst,
  rf_spi_responder_if.slave bus
);

  logic cs_s, sdi_s, sck_rise, sck_fall;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q;
  logic [7:0]        shift_q;
  logic [6:0]        addr_hi_q;
  logic [7:0]        tx_q;
  logic              rd_cap_q;
  logic              wr_pend_q;
  logic              pending_q;
  logic              sdo_q, sdo_oe_q;
  logic              reg_rd_q, reg_wr_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic [7:0]        reg_wdata_q;

  logic [7:0] in_byte;
  logic [7:0] tx_src;
  logic       cmd_last, laddr_last, data_last, rd_end;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
    .clk      (clk),
    .rst      (rst),
    .cs       (bus.cs),
    .sck      (bus.sck),
    .sdi      (bus.sdi),
    .cs_s     (cs_s),
    .sdi_s    (sdi_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  // The byte completing on this rising edge, including the bit being sampled now.
  assign in_byte    = {shift_q[6:0], sdi_s};
  assign cmd_last   = sck_rise && (cnt_q == 8'(SHORT_CMD_BITS - 1));
  assign laddr_last = sck_rise && (cnt_q == 8'(LONG_CMD_BITS - SHORT_CMD_BITS - 1));
  assign data_last  = sck_rise && (cnt_q == 8'(DATA_BITS - 1));
  assign rd_end     = sck_fall && (cnt_q == 8'(DATA_BITS));
  // The first falling edge can land in the cycle read data arrives, so bypass the capture flop.
  assign tx_src     = rd_cap_q ? bus.reg_rdata : tx_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode; a deasserted cs forces IDLE from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!cs_s) state_d = CMD;
      CMD: begin
        if (cmd_last) begin
          if (in_byte[7])                    state_d = LADDR;
          else if (decode_write(SHORT, in_byte)) state_d = DATA_WR;
          else                               state_d = DATA_RD;
        end
      end
      LADDR:   if (laddr_last) state_d = decode_write(LONG, in_byte) ? DATA_WR : DATA_RD;
      DATA_WR: if (data_last) state_d = DONE;
      DATA_RD: if (rd_end) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (cs_s) state_d = IDLE;
  end

  // Bit counting, shifting, address/data capture and register-port strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      addr_hi_q   <= '0;
      tx_q        <= '0;
      rd_cap_q    <= 1'b0;
      wr_pend_q   <= 1'b0;
      reg_rd_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
    end else begin
      reg_rd_q  <= 1'b0;
      wr_pend_q <= 1'b0;
      reg_wr_q  <= wr_pend_q;
      rd_cap_q  <= reg_rd_q;
      if (rd_cap_q) tx_q <= bus.reg_rdata;

      if (state_d != state_q)
        cnt_q <= '0;
      else if ((sck_rise && (state_q inside {CMD, LADDR, DATA_WR})) ||
               (sck_fall && state_q == DATA_RD && cnt_q < 8'(DATA_BITS)))
        cnt_q <= cnt_q + 8'd1;

      if (sck_rise && (state_q inside {CMD, LADDR, DATA_WR})) shift_q <= in_byte;

      if (!cs_s) begin
        case (state_q)
          CMD: begin
            if (cmd_last) begin
              if (in_byte[7]) begin
                addr_hi_q <= in_byte[6:0];
              end else begin
                reg_addr_q <= ADDR_W'(decode_addr(SHORT, 7'd0, in_byte));
                reg_rd_q   <= ~decode_write(SHORT, in_byte);
              end
            end
          end
          LADDR: begin
            if (laddr_last) begin
              reg_addr_q <= ADDR_W'(decode_addr(LONG, addr_hi_q, in_byte));
              reg_rd_q   <= ~decode_write(LONG, in_byte);
            end
          end
          DATA_WR: begin
            if (data_last) begin
              reg_wdata_q <= in_byte;
              wr_pend_q   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read data goes out MSB first on falling edges; the driver releases on the ninth fall or cs rise.
  always_ff @(posedge clk) begin
    if (rst || state_d == IDLE) begin
      sdo_q    <= 1'b0;
      sdo_oe_q <= 1'b0;
    end else if (state_q == DATA_RD && sck_fall) begin
      if (cnt_q < 8'(DATA_BITS)) begin
        sdo_q    <= tx_src[3'd7 - cnt_q[2:0]];
        sdo_oe_q <= 1'b1;
      end else begin
        sdo_q    <= 1'b0;
        sdo_oe_q <= 1'b0;
      end
    end
  end

  // Pending interrupt: set by irq_req, cleared by a read of the status register; set wins.
  always_ff @(posedge clk) begin
    if (rst) pending_q <= 1'b0;
    else     pending_q <= bus.irq_req |
                          (pending_q & ~(reg_rd_q && reg_addr_q == INTSTAT_ADDR));
  end

  assign bus.sdo       = sdo_q;
  assign bus.sdo_oe    = sdo_oe_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_rd    = reg_rd_q;
  assign bus.intr_n    = ~pending_q;

endmodule

// File: tb/tb_rf_spi_responder.sv
// tb/tb_rf_spi_responder.sv - directed self-checking bench for rf_spi_responder
module tb_rf_spi_responder;
  import rf_spi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic irq_manual;
  logic irq_arm;

  int n_tests = 0;
  int n_fail  = 0;

  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [9:0]  wr_addr, rd_addr;
  logic [7:0]  wr_data;
  logic        rd_prev = 1'b0;
  logic        intr_after_rd = 1'b1;

  logic [7:0]  last_rx;
  logic        last_oe_all;
  logic        oe_after;

  logic [7:0]  mem [0:1023];
  logic [7:0]  rdata;

  rf_spi_responder_if #(.ADDR_W(10)) bus ();

  rf_spi_responder #(
    .ADDR_W      (10),
    .INTSTAT_ADDR(10'h031),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Register file outside the responder: write on reg_wr, registered read data.
  always @(posedge clk) begin
    if (bus.reg_wr) mem[bus.reg_addr] <= bus.reg_wdata;
    if (bus.reg_rd) rdata <= mem[bus.reg_addr];
  end

  assign bus.reg_rdata = rdata;
  assign bus.irq_req   = irq_manual | (irq_arm & bus.reg_rd);

  // Strobe monitor sampled on the falling clock edge.
  always @(negedge clk) begin
    if (rd_prev) intr_after_rd = bus.intr_n;
    rd_prev = bus.reg_rd;
    if (bus.reg_wr) begin
      wr_cnt++;
      wr_addr = bus.reg_addr;
      wr_data = bus.reg_wdata;
    end
    if (bus.reg_rd) begin
      rd_cnt++;
      rd_addr = bus.reg_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, input int half,
                          output logic [7:0] rx, output logic oe_all);
    rx     = 8'h00;
    oe_all = 1'b1;
    for (int i = 7; i > 7 - n; i--) begin
      bus.sdi = tx[i];
      repeat (half) @(negedge clk);
      bus.sck = 1'b1;
      repeat (half) @(negedge clk);
      rx[i]  = bus.sdo;
      oe_all = oe_all & bus.sdo_oe;
      bus.sck = 1'b0;
    end
  endtask

  task automatic cs_start(input int half);
    bus.cs = 1'b0;
    repeat (2 * half) @(negedge clk);
  endtask

  task automatic cs_stop();
    repeat (4) @(negedge clk);
    oe_after = bus.sdo_oe;
    bus.cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input int nbytes, input int half);
    logic [7:0] rx;
    logic       oe;
    cs_start(half);
    spi_bits(b0, 8, half, rx, oe);
    spi_bits(b1, 8, half, rx, oe);
    if (nbytes > 2) spi_bits(b2, 8, half, rx, oe);
    last_rx     = rx;
    last_oe_all = oe;
    cs_stop();
  endtask

  initial begin
    int         w0, r0;
    logic [7:0] rx;
    logic       oe;

    rst        = 1'b1;
    irq_manual = 1'b0;
    irq_arm    = 1'b0;
    bus.cs     = 1'b1;
    bus.sck    = 1'b0;
    bus.sdi    = 1'b0;
    repeat (4) @(negedge clk);

    check("rst_sdo",       32'(bus.sdo),       32'h0);
    check("rst_sdo_oe",    32'(bus.sdo_oe),    32'h0);
    check("rst_reg_wr",    32'(bus.reg_wr),    32'h0);
    check("rst_reg_rd",    32'(bus.reg_rd),    32'h0);
    check("rst_reg_addr",  32'(bus.reg_addr),  32'h0);
    check("rst_reg_wdata", 32'(bus.reg_wdata), 32'h0);
    check("rst_intr_n",    32'(bus.intr_n),    32'h1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Short write 0x63 -> addr 0x031, data 0xA5
    w0 = wr_cnt; r0 = rd_cnt;
    xfer(8'h63, 8'hA5, 8'h00, 2, 4);
    check("sw_wr_count", 32'(wr_cnt - w0), 32'd1);
    check("sw_addr",     32'(wr_addr),     32'h031);
    check("sw_data",     32'(wr_data),     32'hA5);
    check("sw_no_rd",    32'(rd_cnt - r0), 32'd0);

    // Load 0x3C into 0x012, then short read it with command 0x24
    xfer(8'h25, 8'h3C, 8'h00, 2, 4);
    r0 = rd_cnt;
    xfer(8'h24, 8'h00, 8'h00, 2, 4);
    check("sr_rd_count", 32'(rd_cnt - r0), 32'd1);
    check("sr_addr",     32'(rd_addr),     32'h012);
    check("sr_data",     32'(last_rx),     32'h3C);
    check("sr_oe_on",    32'(last_oe_all), 32'h1);
    check("sr_oe_off",   32'(oe_after),    32'h0);
    check("sr_sdo_idle", 32'(bus.sdo),     32'h0);

    // Long write to 0x200 (addr[9:3]=0x40 -> 0xC0, then 0x10), data 0x5A
    w0 = wr_cnt;
    xfer(8'hC0, 8'h10, 8'h5A, 3, 4);
    check("lw_wr_count", 32'(wr_cnt - w0), 32'd1);
    check("lw_addr",     32'(wr_addr),     32'h200);
    check("lw_data",     32'(wr_data),     32'h5A);

    // Long write 0x81 to 0x3FF, then long read it back (low nibble of byte 2 ignored)
    xfer(8'hFF, 8'hF0, 8'h81, 3, 4);
    r0 = rd_cnt;
    xfer(8'hFF, 8'hE5, 8'h00, 3, 4);
    check("lr_rd_count", 32'(rd_cnt - r0), 32'd1);
    check("lr_addr",     32'(rd_addr),     32'h3FF);
    check("lr_data",     32'(last_rx),     32'h81);
    check("lr_oe_on",    32'(last_oe_all), 32'h1);

    // Abort a short write after four data bits, then a clean write of 0x77 to 0x002
    w0 = wr_cnt;
    cs_start(4);
    spi_bits(8'h63, 8, 4, rx, oe);
    spi_bits(8'h5A, 4, 4, rx, oe);
    cs_stop();
    check("abort_no_wr", 32'(wr_cnt - w0), 32'd0);
    xfer(8'h05, 8'h77, 8'h00, 2, 4);
    check("abort_next_count", 32'(wr_cnt - w0), 32'd1);
    check("abort_next_addr",  32'(wr_addr),     32'h002);
    check("abort_next_data",  32'(wr_data),     32'h77);

    // Interrupt set, cleared by a read of 0x031 (command 0x62)
    irq_manual = 1'b1;
    @(negedge clk);
    irq_manual = 1'b0;
    repeat (2) @(negedge clk);
    check("irq_set", 32'(bus.intr_n), 32'h0);
    xfer(8'h62, 8'h00, 8'h00, 2, 4);
    check("irq_read_data", 32'(last_rx),       32'hA5);
    check("irq_cleared",   32'(intr_after_rd), 32'h1);

    // Set again, then have irq_req coincide with the clearing reg_rd: set wins
    irq_manual = 1'b1;
    @(negedge clk);
    irq_manual = 1'b0;
    repeat (2) @(negedge clk);
    check("irq_set2", 32'(bus.intr_n), 32'h0);
    irq_arm = 1'b1;
    xfer(8'h62, 8'h00, 8'h00, 2, 4);
    irq_arm = 1'b0;
    check("irq_set_wins", 32'(intr_after_rd), 32'h0);
    check("irq_still_0",  32'(bus.intr_n),    32'h0);

    // Reset in the middle of a read of 0x020 (holding 0xF0)
    xfer(8'h41, 8'hF0, 8'h00, 2, 4);
    cs_start(4);
    spi_bits(8'h40, 8, 4, rx, oe);
    spi_bits(8'h00, 3, 4, rx, oe);
    check("mid_oe_high",  32'(bus.sdo_oe), 32'h1);
    check("mid_rx_bits",  32'(rx[7:5]),    32'h7);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_sdo",   32'(bus.sdo),     32'h0);
    check("mid_rst_oe",    32'(bus.sdo_oe),  32'h0);
    check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    bus.cs = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_rst_intr_n", 32'(bus.intr_n), 32'h1);

    // Transactions at sck = clk/4
    r0 = rd_cnt;
    xfer(8'h24, 8'h00, 8'h00, 2, 2);
    check("fast_rd_count", 32'(rd_cnt - r0), 32'd1);
    check("fast_rd_addr",  32'(rd_addr),     32'h012);
    check("fast_rd_data",  32'(last_rx),     32'h3C);
    w0 = wr_cnt;
    xfer(8'h0B, 8'hC3, 8'h00, 2, 2);
    check("fast_wr_count", 32'(wr_cnt - w0), 32'd1);
    check("fast_wr_addr",  32'(wr_addr),     32'h005);
    check("fast_wr_data",  32'(wr_data),     32'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
